// File: rtl/qft3_peak_detector.sv
// Peak/power detector for the 3-qubit QFT output vector: captures eight complex
// amplitudes, evaluates |a|^2 serially with one shared squarer pair, reports the peak and total power.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif

module qft3_peak_detector #(
    parameter int W = `TOTAL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [W-1:0]   f000_r,
    input  logic signed [W-1:0]   f000_i,
    input  logic signed [W-1:0]   f001_r,
    input  logic signed [W-1:0]   f001_i,
    input  logic signed [W-1:0]   f010_r,
    input  logic signed [W-1:0]   f010_i,
    input  logic signed [W-1:0]   f011_r,
    input  logic signed [W-1:0]   f011_i,
    input  logic signed [W-1:0]   f100_r,
    input  logic signed [W-1:0]   f100_i,
    input  logic signed [W-1:0]   f101_r,
    input  logic signed [W-1:0]   f101_i,
    input  logic signed [W-1:0]   f110_r,
    input  logic signed [W-1:0]   f110_i,
    input  logic signed [W-1:0]   f111_r,
    input  logic signed [W-1:0]   f111_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            peak_idx,
    output logic [2*W-1:0]        peak_mag,
    output logic [2*W+2:0]        total_pwr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // |a|^2 of one complex sample; each square fits 2W-1 bits, the sum fits 2W unsigned
    function automatic logic [2*W-1:0] sq_mag(input logic signed [W-1:0] re,
                                              input logic signed [W-1:0] im);
        logic signed [2*W-1:0] pr;
        logic signed [2*W-1:0] pi;
        pr = re * re;
        pi = im * im;
        sq_mag = $unsigned(pr) + $unsigned(pi);
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [2:0]             k_r;
    logic signed [W-1:0]    vec_re_r [8];
    logic signed [W-1:0]    vec_im_r [8];
    logic signed [W-1:0]    amp_re_s [8];
    logic signed [W-1:0]    amp_im_s [8];
    logic [2*W-1:0]         max_r;
    logic [2:0]             idx_r;
    logic [2*W+2:0]         sum_r;
    logic [2*W-1:0]         mag_s;
    logic                   upd_s;
    logic [2*W-1:0]         new_max_s;
    logic [2:0]             new_idx_s;
    logic [2*W+2:0]         new_sum_s;
    logic                   capture_s;
    logic                   last_s;
    logic [2:0]             peak_idx_r;
    logic [2*W-1:0]         peak_mag_r;
    logic [2*W+2:0]         total_pwr_r;

    assign amp_re_s[0] = f000_r;  assign amp_im_s[0] = f000_i;
    assign amp_re_s[1] = f001_r;  assign amp_im_s[1] = f001_i;
    assign amp_re_s[2] = f010_r;  assign amp_im_s[2] = f010_i;
    assign amp_re_s[3] = f011_r;  assign amp_im_s[3] = f011_i;
    assign amp_re_s[4] = f100_r;  assign amp_im_s[4] = f100_i;
    assign amp_re_s[5] = f101_r;  assign amp_im_s[5] = f101_i;
    assign amp_re_s[6] = f110_r;  assign amp_im_s[6] = f110_i;
    assign amp_re_s[7] = f111_r;  assign amp_im_s[7] = f111_i;

    // Handshake flags come straight from the state register
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign capture_s = in_valid && (state_r == IDLE);
    assign last_s    = (state_r == CALC) && (k_r == 3'd7);

    assign peak_idx  = peak_idx_r;
    assign peak_mag  = peak_mag_r;
    assign total_pwr = total_pwr_r;

    // Shared squarer and running compare/accumulate for element k
    always_comb begin
        mag_s     = sq_mag(vec_re_r[k_r], vec_im_r[k_r]);
        upd_s     = 1'b0;
        new_max_s = max_r;
        new_idx_s = idx_r;
        new_sum_s = sum_r + {3'b000, mag_s};
        // Strict compare keeps the lowest index on ties
        if ((k_r == 3'd0) || (mag_s > max_r)) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
        if (upd_s) begin
            new_max_s = mag_s;
            new_idx_s = k_r;
        end else begin
            new_max_s = max_r;
            new_idx_s = idx_r;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (k_r == 3'd7) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Vector capture, element counter and running max/index/sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r   <= 3'd0;
            max_r <= '0;
            idx_r <= 3'd0;
            sum_r <= '0;
            for (int j = 0; j < 8; j++) begin
                vec_re_r[j] <= '0;
                vec_im_r[j] <= '0;
            end
        end else if (capture_s) begin
            k_r   <= 3'd0;
            max_r <= '0;
            idx_r <= 3'd0;
            sum_r <= '0;
            for (int j = 0; j < 8; j++) begin
                vec_re_r[j] <= amp_re_s[j];
                vec_im_r[j] <= amp_im_s[j];
            end
        end else if (state_r == CALC) begin
            k_r   <= k_r + 3'd1;
            max_r <= new_max_s;
            idx_r <= new_idx_s;
            sum_r <= new_sum_s;
        end
    end

    // Result registers: loaded on the last CALC edge, held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_idx_r  <= 3'd0;
            peak_mag_r  <= '0;
            total_pwr_r <= '0;
        end else if (last_s) begin
            peak_idx_r  <= new_idx_s;
            peak_mag_r  <= new_max_s;
            total_pwr_r <= new_sum_s;
        end
    end

endmodule

// File: tb/tb_qft3_peak_detector.sv
// Self-checking bench for qft3_peak_detector: abstract transaction model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_qft3_peak_detector;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [W-1:0] vr [8];
    logic signed [W-1:0] vi [8];
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    logic [2:0] peak_idx;
    logic [2*W-1:0] peak_mag;
    logic [2*W+2:0] total_pwr;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    qft3_peak_detector #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .f000_r(vr[0]), .f000_i(vi[0]), .f001_r(vr[1]), .f001_i(vi[1]),
        .f010_r(vr[2]), .f010_i(vi[2]), .f011_r(vr[3]), .f011_i(vi[3]),
        .f100_r(vr[4]), .f100_i(vi[4]), .f101_r(vr[5]), .f101_i(vi[5]),
        .f110_r(vr[6]), .f110_i(vi[6]), .f111_r(vr[7]), .f111_i(vi[7]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .peak_idx(peak_idx), .peak_mag(peak_mag), .total_pwr(total_pwr)
    );

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // mode: 0 accepting, 1 evaluating, 2 presenting a result
    int m_mode = 0;
    int m_cnt = 0;
    int cyc = 0;
    longint pend_idx, pend_mag, pend_pwr;
    longint exp_idx = 0, exp_mag = 0, exp_pwr = 0;
    int caps[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0;
            exp_idx = 0; exp_mag = 0; exp_pwr = 0;
        end else begin
            cyc++;
            if (m_mode == 0) begin
                if (in_valid) begin
                    longint best, m, s;
                    best = -1; s = 0; pend_idx = 0;
                    for (int j = 0; j < 8; j++) begin
                        m = longint'(vr[j]) * longint'(vr[j]) + longint'(vi[j]) * longint'(vi[j]);
                        s += m;
                        if (m > best) begin best = m; pend_idx = j; end
                    end
                    pend_mag = best; pend_pwr = s;
                    m_mode = 1; m_cnt = 0;
                    caps.push_back(cyc);
                end
            end else if (m_mode == 1) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    m_mode = 2;
                    exp_idx = pend_idx; exp_mag = pend_mag; exp_pwr = pend_pwr;
                end
            end else begin
                if (out_ready) m_mode = 0;
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        check("in_ready", in_ready, (m_mode == 0) ? 1 : 0);
        check("out_valid", out_valid, (m_mode == 2) ? 1 : 0);
        check("peak_idx", peak_idx, exp_idx);
        check("peak_mag", peak_mag, exp_mag);
        check("total_pwr", total_pwr, exp_pwr);
    end

    // ---------------- directed helpers ----------------
    task automatic clear_vec();
        for (int j = 0; j < 8; j++) begin vr[j] = '0; vi[j] = '0; end
    endtask

    task automatic rand_vec();
        for (int j = 0; j < 8; j++) begin
            vr[j] = W'($urandom);
            vi[j] = W'($urandom);
        end
    endtask

    // Pulse in_valid for one edge, measure latency, check literal result, optionally hand off
    task automatic run_vec(input string name, input longint e_idx, input longint e_mag,
                           input longint e_pwr, input bit handshake);
        int n;
        check({name, "_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        check({name, "_latency"}, n, 8);
        check({name, "_idx"}, peak_idx, e_idx);
        check({name, "_mag"}, peak_mag, e_mag);
        check({name, "_pwr"}, total_pwr, e_pwr);
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({name, "_ov_after_hs"}, out_valid, 0);
            check({name, "_ir_after_hs"}, in_ready, 1);
        end
    endtask

    initial begin
        clear_vec();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_peak_idx", peak_idx, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_total_pwr", total_pwr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        clear_vec(); vr[3] = 8'sd16;
        run_vec("single", 3, 256, 256, 1'b1);

        for (int j = 0; j < 8; j++) begin vr[j] = 8'sd4; vi[j] = -8'sd4; end
        run_vec("tie", 0, 32, 256, 1'b1);

        for (int j = 0; j < 8; j++) begin vr[j] = -8'sd128; vi[j] = -8'sd128; end
        run_vec("fullscale", 0, 32768, 262144, 1'b1);

        for (int j = 0; j < 8; j++) begin vr[j] = 8'sd1; vi[j] = 8'sd0; end
        vr[7] = -8'sd128; vi[7] = -8'sd128;
        run_vec("peak7", 7, 32768, 32775, 1'b1);

        // Backpressure: result must hold while new data and in_valid toggle
        clear_vec(); vi[2] = 8'sd10; vr[6] = 8'sd3; vi[6] = 8'sd4;
        run_vec("bp", 2, 100, 125, 1'b0);
        for (int c = 0; c < 20; c++) begin
            rand_vec();
            in_valid = ~in_valid;
            @(posedge clk); #1;
            check("bp_hold_ov", out_valid, 1);
            check("bp_hold_ir", in_ready, 0);
            check("bp_hold_idx", peak_idx, 2);
            check("bp_hold_mag", peak_mag, 100);
            check("bp_hold_pwr", total_pwr, 125);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_ov", out_valid, 0);
        check("bp_release_ir", in_ready, 1);

        // Reset during CALC aborts the vector
        clear_vec(); vr[0] = 8'sd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ir", in_ready, 1);
        check("midrst_ov", out_valid, 0);
        check("midrst_idx", peak_idx, 0);
        check("midrst_mag", peak_mag, 0);
        check("midrst_pwr", total_pwr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_vec(); vi[5] = -8'sd16;
        run_vec("after_rst", 5, 256, 256, 1'b1);

        // Streaming: captures only every 10 cycles
        caps.delete();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            rand_vec();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stream_caps", caps.size(), 6);
        for (int j = 1; j < caps.size(); j++) begin
            check("stream_interval", caps[j] - caps[j-1], 10);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
